lab_stream_ctrl: RTL and testbench

//  Stream sequencer for the free-running, non-stallable RGB->CIE-Lab datapath (rgb_to_lab_verb).

---
 rtl/lab_stream_ctrl_pkg.sv | 32 +++
 rtl/lab_stream_ctrl_out_fifo.sv | 73 +++++++
 rtl/lab_stream_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lab_stream_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab_stream_ctrl_pkg.sv
// Shared definitions for the lab_stream_ctrl slice.
//   LAB_DSIZE / LAB_LATENCY / LAB_FIFO_DEPTH : default sizing
//   TAG_VLD / TAG_SOF / TAG_EOL              : bit positions inside an in-flight tag
//   state_t                                  : sequencer states
//   make_tag()                               : builds a valid tag from frame sideband
package lab_stream_ctrl_pkg;

  localparam int LAB_DSIZE      = 16;
  localparam int LAB_LATENCY    = 12;
  localparam int LAB_FIFO_DEPTH = 16;

  localparam int TAG_W   = 3;
  localparam int TAG_VLD = 2;
  localparam int TAG_SOF = 1;
  localparam int TAG_EOL = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic sof, input logic eol);
    logic [TAG_W-1:0] t;
    t          = '0;
    t[TAG_VLD] = 1'b1;
    t[TAG_SOF] = sof;
    t[TAG_EOL] = eol;
    return t;
  endfunction

endpackage

// File: rtl/lab_stream_ctrl_out_fifo.sv
// lab_out_fifo: synchronous first-word-fall-through FIFO for Lab results.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of pointers and count (wins over wr/rd)
//   wr, wdata  : push; ignored when full unless a pop happens the same edge
//   rd         : pop the head; ignored when empty
//   rdata      : head entry, forced to 0 while empty
//   cnt        : number of stored entries
//   full/empty : status flags derived from cnt
module lab_out_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             w_do_rd;
  logic             w_do_wr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (r_cnt == '0);
  assign full    = (r_cnt == CW'(DEPTH));
  assign cnt     = r_cnt;
  assign w_do_rd = rd & ~empty;
  // When full, a same-edge pop frees the head slot, which is exactly where
  // the write pointer sits, so the write may proceed.
  assign w_do_wr = wr & (~full | w_do_rd);
  assign rdata   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr && !clr) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lab_stream_ctrl.sv
// lab_stream_ctrl: stream sequencer for the free-running RGB->CIE-Lab datapath.
// Accepts valid/ready RGB pixels, registers them onto dp_R/G/B, tracks each
// pixel through a LATENCY-stage tag shift register, and lands the datapath
// result plus frame sideband in an output FWFT FIFO. Admission is credit based
// (inflight + fifo_cnt < FIFO_DEPTH) so no result is lost under backpressure.
//   clock, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready       : input handshake; s_r/s_g/s_b pixel, s_sof/s_eol sideband
//   flush                 : abort stream, discard in-flight and queued results
//   dp_R/dp_G/dp_B        : registered RGB into the datapath
//   dp_L/dp_A/dp_Bl       : Lab result from the datapath (dp_Bl is b*; dp_B is blue)
//   m_valid/m_ready       : output handshake; m_L/m_A/m_B result, m_sof/m_eol sideband
//   busy                  : state not idle, pixels in flight or results queued
//   ovf_err               : sticky, FIFO written while full without a pop
module lab_stream_ctrl
  import lab_stream_ctrl_pkg::*;
#(
  parameter int DSIZE      = LAB_DSIZE,
  parameter int LATENCY    = LAB_LATENCY,
  parameter int FIFO_DEPTH = LAB_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_r,
  input  logic [DSIZE-1:0] s_g,
  input  logic [DSIZE-1:0] s_b,
  input  logic             s_sof,
  input  logic             s_eol,
  input  logic             flush,
  output logic [DSIZE-1:0] dp_R,
  output logic [DSIZE-1:0] dp_G,
  output logic [DSIZE-1:0] dp_B,
  input  logic [DSIZE-1:0] dp_L,
  input  logic [DSIZE-1:0] dp_A,
  input  logic [DSIZE-1:0] dp_Bl,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_L,
  output logic [DSIZE-1:0] m_A,
  output logic [DSIZE-1:0] m_B,
  output logic             m_sof,
  output logic             m_eol,
  output logic             busy,
  output logic             ovf_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = 3 * DSIZE + 2;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [LATENCY-1:0][TAG_W-1:0] r_tag;
  logic [LATENCY:0][TAG_W-1:0]   w_tag_shift;
  logic [TAG_W-1:0]              w_tag_in;
  logic [TAG_W-1:0]              w_exit_tag;
  logic [CW-1:0]                 r_inflight;
  logic                          r_ovf;
  logic [CW-1:0]                 w_fifo_cnt;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [CW:0]                   w_credit_used;
  logic                          w_issue;
  logic                          w_exit;
  logic                          w_pop;
  logic                          w_fifo_wr;
  logic [FW-1:0]                 w_fifo_wdata;
  logic [FW-1:0]                 w_fifo_rdata;

  // Every in-flight pixel owns a FIFO slot in advance, so a landing result
  // always finds room even if the consumer stalls for the whole latency.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_cnt};
  // Gated by rst_n so s_ready reads 0 while reset is held; flush blocks
  // admission combinationally in the cycle it is raised.
  assign s_ready = rst_n & ~flush & (r_state != ST_FLUSH)
                 & (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign w_issue = s_valid & s_ready;

  assign w_tag_in    = w_issue ? make_tag(s_sof, s_eol) : '0;
  assign w_tag_shift = {r_tag, w_tag_in};
  assign w_exit_tag  = r_tag[LATENCY-1];
  assign w_exit      = w_exit_tag[TAG_VLD];

  assign m_valid      = ~w_fifo_empty & (r_state != ST_FLUSH);
  assign w_pop        = m_valid & m_ready;
  assign w_fifo_wr    = w_exit & (r_state != ST_FLUSH);
  assign w_fifo_wdata = {dp_L, dp_A, dp_Bl, w_exit_tag[TAG_SOF], w_exit_tag[TAG_EOL]};
  assign {m_L, m_A, m_B, m_sof, m_eol} = w_fifo_rdata;

  assign busy    = (r_state != ST_IDLE) | (r_inflight != '0) | ~w_fifo_empty;
  assign ovf_err = r_ovf;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dp_R <= '0;
      dp_G <= '0;
      dp_B <= '0;
    end else if (w_issue) begin
      dp_R <= s_r;
      dp_G <= s_g;
      dp_B <= s_b;
    end
  end

  // Idle slots carry an all-zero tag, so stale datapath output is ignored.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_tag <= '0;
    else        r_tag <= w_tag_shift[LATENCY-1:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_exit})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                                      r_ovf <= 1'b0;
    else if (w_fifo_wr && w_fifo_full && !w_pop && !flush) r_ovf <= 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_issue) w_state_next = ST_RUN;
        ST_RUN:   if ((r_inflight == '0) && w_fifo_empty && !w_issue) w_state_next = ST_IDLE;
        ST_FLUSH: if (r_inflight == '0) w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  lab_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clock),
    .rst_n (rst_n),
    .clr   (flush),
    .wr    (w_fifo_wr),
    .wdata (w_fifo_wdata),
    .rd    (w_pop),
    .rdata (w_fifo_rdata),
    .cnt   (w_fifo_cnt),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_lab_stream_ctrl.sv
// Scoreboard bench for lab_stream_ctrl. The datapath is modelled as an
// identity pipeline (L=R, A=G, b=B) whose result for a pixel registered on
// dp_* at edge k is presented for sampling at edge k+LATENCY.
module tb_lab_stream_ctrl;

  localparam int DSIZE      = 16;
  localparam int LATENCY    = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int PW         = 3 * DSIZE;
  localparam int SBW        = PW + 2;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DSIZE-1:0] s_r = '0, s_g = '0, s_b = '0;
  logic             s_sof = 1'b0, s_eol = 1'b0;
  logic             flush = 1'b0;
  logic [DSIZE-1:0] dp_R, dp_G, dp_B;
  logic [DSIZE-1:0] dp_L, dp_A, dp_Bl;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DSIZE-1:0] m_L, m_A, m_B;
  logic             m_sof, m_eol;
  logic             busy, ovf_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int out_cnt = 0;
  int last_issue_cyc = 0;
  logic arm_first = 1'b0;
  int first_valid_cyc = -1;
  logic [SBW-1:0] sb[$];
  logic [SBW-1:0] exp_v;
  logic [PW-1:0]  dp_pipe [LATENCY-1];

  lab_stream_ctrl #(
    .DSIZE      (DSIZE),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_r     (s_r),
    .s_g     (s_g),
    .s_b     (s_b),
    .s_sof   (s_sof),
    .s_eol   (s_eol),
    .flush   (flush),
    .dp_R    (dp_R),
    .dp_G    (dp_G),
    .dp_B    (dp_B),
    .dp_L    (dp_L),
    .dp_A    (dp_A),
    .dp_Bl   (dp_Bl),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_L     (m_L),
    .m_A     (m_A),
    .m_B     (m_B),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .busy    (busy),
    .ovf_err (ovf_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Identity datapath: LATENCY-1 register stages after the dp_* registers.
  always @(posedge clock) begin
    dp_pipe[0] <= {dp_R, dp_G, dp_B};
    for (int i = 1; i < LATENCY - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign {dp_L, dp_A, dp_Bl} = dp_pipe[LATENCY-2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int t, input int i);
    logic [DSIZE-1:0] r, g, b;
    r = DSIZE'(t * 4096 + i);
    g = DSIZE'(16'h5A00 + i * 17);
    b = DSIZE'(16'hF0F0 ^ i);
    return {r, g, b};
  endfunction

  // Monitor: pops the expected entry whenever the DUT hands over a result.
  always @(negedge clock) begin
    if (rst_n && m_valid) begin
      if (arm_first && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexpected: got 0x%0h, expected no output (t=%0t)",
                   {m_L, m_A, m_B, m_sof, m_eol}, $time);
        end else begin
          exp_v = sb.pop_front();
          chk("out_data", {m_L, m_A, m_B, m_sof, m_eol}, exp_v);
          out_cnt++;
        end
      end
    end
  end

  // Entered and left at posedge+1; pushes the expectation when accepted.
  task automatic send(input logic [PW-1:0] rgb, input logic sof, input logic eol,
                      output int stalls);
    {s_r, s_g, s_b} = rgb;
    s_sof   = sof;
    s_eol   = eol;
    s_valid = 1'b1;
    stalls  = 0;
    forever begin
      @(negedge clock);
      if (s_ready) begin
        sb.push_back({rgb, sof, eol});
        last_issue_cyc = cyc + 1;
        @(posedge clock); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        return;
      end
      stalls++;
      if (stalls > 300) begin
        chk("send_timeout", stalls, 0);
        s_valid = 1'b0;
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 300) begin
      @(negedge clock);
      c++;
    end
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_busy_low"}, busy, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st, tot, o0, first_issue, acc, c, k;
    logic mv_seen, sr_seen;

    for (int i = 0; i < LATENCY - 1; i++) dp_pipe[i] = '0;

    // Reset state, with s_valid asserted to show s_ready stays low.
    s_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_dp", {dp_R, dp_G, dp_B}, 0);
    chk("rst_m_data", {m_L, m_A, m_B, m_sof, m_eol}, 0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_s_ready", s_ready, 1);

    // 1: 64-pixel burst with free-flowing output.
    m_ready = 1'b1;
    arm_first = 1'b1;
    first_valid_cyc = -1;
    o0 = out_cnt;
    tot = 0;
    first_issue = 0;
    for (int i = 0; i < 64; i++) begin
      send(pix(1, i), 1'b0, 1'b0, st);
      if (i == 0) first_issue = last_issue_cyc;
      tot += st;
    end
    drain("t1");
    arm_first = 1'b0;
    chk("t1_stalls", tot, 0);
    chk("t1_first_valid_latency", first_valid_cyc - first_issue, LATENCY);
    chk("t1_out_count", out_cnt - o0, 64);
    chk("t1_ovf", ovf_err, 0);

    // 2: consumer stalled, offer 40 pixels; only FIFO_DEPTH may be admitted.
    m_ready = 1'b0;
    o0 = out_cnt;
    acc = 0;
    {s_r, s_g, s_b} = pix(2, 0);
    s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (s_ready) begin
        sb.push_back({s_r, s_g, s_b, 2'b00});
        acc++;
      end
      @(posedge clock); #1;
      {s_r, s_g, s_b} = pix(2, acc);
      if (acc >= 40) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    chk("t2_accepted", acc, FIFO_DEPTH);
    chk("t2_s_ready_full", s_ready, 0);
    chk("t2_m_valid_held", m_valid, 1);
    chk("t2_busy", busy, 1);
    m_ready = 1'b1;
    drain("t2");
    chk("t2_out_count", out_cnt - o0, FIFO_DEPTH);
    chk("t2_ovf", ovf_err, 0);

    // 3: sideband alignment (sof on pixel 0, eol on pixel 7).
    o0 = out_cnt;
    for (int i = 0; i < 8; i++) send(pix(3, i), i == 0, i == 7, st);
    drain("t3");
    chk("t3_out_count", out_cnt - o0, 8);

    // 4: flush after 5 issued pixels with the consumer stalled.
    m_ready = 1'b0;
    o0 = out_cnt;
    for (int i = 0; i < 5; i++) send(pix(4, i), i == 0, 1'b0, st);
    {s_r, s_g, s_b} = pix(4, 5);
    s_valid = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    chk("t4_s_ready_on_flush", s_ready, 0);
    @(posedge clock); #1;
    flush = 1'b0;
    sb.delete();
    mv_seen = 1'b0;
    sr_seen = 1'b0;
    c = 0;
    while (c < LATENCY + 2) begin
      @(negedge clock);
      if (!busy) begin
        s_valid = 1'b0;
        break;
      end
      mv_seen |= m_valid;
      sr_seen |= s_ready;
      c++;
    end
    s_valid = 1'b0;
    chk("t4_idle_within_latency", busy, 0);
    chk("t4_m_valid_during_flush", mv_seen, 0);
    chk("t4_s_ready_during_flush", sr_seen, 0);
    @(posedge clock); #1;
    chk("t4_s_ready_after_idle", s_ready, 1);
    m_ready = 1'b1;
    repeat (LATENCY + 4) @(posedge clock);
    #1;
    chk("t4_nothing_released", out_cnt - o0, 0);

    // 5: FIFO filled, one slot freed, then a pop coincides with the landing write.
    m_ready = 1'b0;
    o0 = out_cnt;
    for (int i = 0; i < FIFO_DEPTH; i++) send(pix(5, i), 1'b0, i == FIFO_DEPTH - 1, st);
    repeat (LATENCY + 2) @(posedge clock);
    #1;
    chk("t5_s_ready_full", s_ready, 0);
    chk("t5_ovf_full", ovf_err, 0);
    m_ready = 1'b1;
    @(posedge clock); #1;
    m_ready = 1'b0;
    send(pix(5, 100), 1'b1, 1'b1, st);
    chk("t5_refill_stalls", st, 0);
    k = last_issue_cyc;
    c = 0;
    while (cyc < k + LATENCY - 1 && c < 100) begin
      @(posedge clock); #1;
      c++;
    end
    chk("t5_m_valid_before_exit", m_valid, 1);
    m_ready = 1'b1;
    @(posedge clock); #1;
    m_ready = 1'b0;
    chk("t5_ovf_after_pop_write", ovf_err, 0);
    chk("t5_m_valid_after_pop_write", m_valid, 1);
    chk("t5_s_ready_one_free", s_ready, 1);
    m_ready = 1'b1;
    drain("t5");
    chk("t5_out_count", out_cnt - o0, FIFO_DEPTH + 1);
    chk("t5_ovf", ovf_err, 0);

    // 6: asynchronous reset in the middle of a burst, then a clean frame.
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(pix(6, i), i == 0, 1'b0, st);
    chk("t6_m_valid_before_rst", m_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_ready", s_ready, 0);
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_dp", {dp_R, dp_G, dp_B}, 0);
    chk("t6_rst_m_data", {m_L, m_A, m_B, m_sof, m_eol}, 0);
    sb.delete();
    @(posedge clock);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    o0 = out_cnt;
    for (int i = 0; i < 10; i++) send(pix(7, i), i == 0, i == 9, st);
    drain("t6");
    chk("t6_out_count", out_cnt - o0, 10);
    chk("t6_ovf", ovf_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
